// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection signal controller.
// Light vectors are ordered {light4, light3, light2, light1}.
package traffic_pkg;

    localparam int DEM_W = 9;

    typedef enum logic [1:0] {
        A_GREEN = 2'd0,
        A_CLEAR = 2'd1,
        B_GREEN = 2'd2,
        B_CLEAR = 2'd3
    } phase_t;

    function automatic logic [3:0] light_decode(input phase_t p);
        logic [3:0] l;
        case (p)
            A_GREEN: l = 4'b0101;
            B_GREEN: l = 4'b1010;
            default: l = 4'b0000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
// The strobe is high in the cycle where the counter sits at its last value.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-axis adaptive phase controller with all-stop clearance and manual pin.
// All state advances only on the 1 s tick; outputs are fully registered.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int CLEAR_T   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    input  logic [7:0] q3,
    input  logic [7:0] q4,
    input  logic       man_en,
    input  logic       man_sel,
    output logic       light1,
    output logic       light2,
    output logic       light3,
    output logic       light4,
    output logic [1:0] phase,
    output logic [7:0] sec,
    output logic       tick
);

    localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
    localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
    localparam logic [7:0] CLR_T = 8'(CLEAR_T);

    phase_t           phase_q, phase_nx;
    logic [7:0]       sec_q, sec_nx, n;
    logic [3:0]       lights_q;
    logic [DEM_W-1:0] dA, dB;
    logic             leave_a, leave_b;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign dA = DEM_W'(q1) + DEM_W'(q3);
    assign dB = DEM_W'(q2) + DEM_W'(q4);
    assign n  = (sec_q == 8'hFF) ? 8'hFF : sec_q + 8'd1;

    // A green axis yields only to opposing demand; its own demand extends it up to MAX
    assign leave_a = (man_en && man_sel) ||
                     (!man_en && n >= MIN_G && dB != '0 && (dA == '0 || n >= MAX_G));
    assign leave_b = (man_en && !man_sel) ||
                     (!man_en && n >= MIN_G && dA != '0 && (dB == '0 || n >= MAX_G));

    always_comb begin
        phase_nx = phase_q;
        case (phase_q)
            A_GREEN: if (leave_a) phase_nx = A_CLEAR;
            A_CLEAR: if (n >= CLR_T) phase_nx = (man_en && !man_sel) ? A_GREEN : B_GREEN;
            B_GREEN: if (leave_b) phase_nx = B_CLEAR;
            B_CLEAR: if (n >= CLR_T) phase_nx = (man_en && man_sel) ? B_GREEN : A_GREEN;
        endcase
        sec_nx = (phase_nx != phase_q) ? 8'd0 : n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= A_GREEN;
            sec_q    <= 8'd0;
            lights_q <= light_decode(A_GREEN);
        end else if (tick) begin
            phase_q  <= phase_nx;
            sec_q    <= sec_nx;
            lights_q <= light_decode(phase_nx);
        end
    end

    assign phase  = phase_q;
    assign sec    = sec_q;
    assign light1 = lights_q[0];
    assign light2 = lights_q[1];
    assign light3 = lights_q[2];
    assign light4 = lights_q[3];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a short tick divider.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q1 = 8'd0, q2 = 8'd0, q3 = 8'd0, q4 = 8'd0;
    logic       man_en = 1'b0, man_sel = 1'b0;
    logic       light1, light2, light3, light4, tick;
    logic [1:0] phase;
    logic [7:0] sec;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cyc = 0;

    traffic_phase_ctrl #(
        .TICK_DIV(4), .MIN_GREEN(3), .MAX_GREEN(6), .CLEAR_T(2)
    ) dut (
        .clk(clk), .rst(rst),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4),
        .man_en(man_en), .man_sel(man_sel),
        .light1(light1), .light2(light2), .light3(light3), .light4(light4),
        .phase(phase), .sec(sec), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // lights compared as {light1,light2,light3,light4}
    task automatic check_state(input string tag, input int ph, input int s, input int lt);
        check({tag, ".phase"}, int'(phase), ph);
        check({tag, ".sec"}, int'(sec), s);
        check({tag, ".lights"}, int'({light1, light2, light3, light4}), lt);
    endtask

    task automatic step_tick();
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (tick) got = 1'b1;
        end
        if (!got) check("tick_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_ticks(input int k);
        for (int i = 0; i < k; i++) step_tick();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst_cyc = cyc;
        check_state(tag, 0, 0, 4'b1010);
        check({tag, ".tick"}, int'(tick), 0);
        rst = 1'b0;
    endtask

    task automatic set_q(input int a, input int b, input int c, input int d);
        q1 = 8'(a); q2 = 8'(b); q3 = 8'(c); q4 = 8'(d);
    endtask

    initial begin
        // 1: idle, sec saturates
        set_q(0, 0, 0, 0);
        do_reset("t1_rst");
        step_ticks(255);
        check_state("t1_255", 0, 255, 4'b1010);
        step_ticks(45);
        check_state("t1_300", 0, 255, 4'b1010);

        // 2: demand on B only
        set_q(0, 5, 0, 0);
        do_reset("t2_rst");
        step_ticks(2);
        check_state("t2_k2", 0, 2, 4'b1010);
        step_tick();
        check_state("t2_k3", 1, 0, 4'b0000);
        check("t2_cyc", cyc - rst_cyc, 12);
        step_tick();
        check_state("t2_k4", 1, 1, 4'b0000);
        step_tick();
        check_state("t2_k5", 2, 0, 4'b0101);

        // 3: contention, both axes run to max
        set_q(9, 1, 0, 0);
        do_reset("t3_rst");
        step_ticks(5);
        check_state("t3_k5", 0, 5, 4'b1010);
        step_tick();
        check_state("t3_k6", 1, 0, 4'b0000);
        step_ticks(2);
        check_state("t3_k8", 2, 0, 4'b0101);
        step_ticks(5);
        check_state("t3_k13", 2, 5, 4'b0101);
        step_tick();
        check_state("t3_k14", 3, 0, 4'b0000);
        step_ticks(2);
        check_state("t3_k16", 0, 0, 4'b1010);

        // 4: own demand drops; mid-interval glitch must be ignored
        set_q(4, 2, 0, 0);
        do_reset("t4_rst");
        step_ticks(2);
        q1 = 8'd0;
        @(posedge clk); #1;
        q1 = 8'd4;
        step_tick();
        check_state("t4_k3", 0, 3, 4'b1010);
        q1 = 8'd0;
        step_tick();
        check_state("t4_k4", 1, 0, 4'b0000);

        // 5: manual pin to A from B_GREEN
        set_q(0, 50, 0, 0);
        do_reset("t5_rst");
        step_ticks(6);
        check_state("t5_b1", 2, 1, 4'b0101);
        man_en = 1'b1; man_sel = 1'b0;
        step_tick();
        check_state("t5_bclr", 3, 0, 4'b0000);
        step_ticks(2);
        check_state("t5_agrn", 0, 0, 4'b1010);
        q1 = 8'd3;
        step_ticks(20);
        check_state("t5_hold", 0, 20, 4'b1010);
        man_en = 1'b0;
        step_tick();
        check_state("t5_rel", 1, 0, 4'b0000);

        // 6: reset mid-clearance
        set_q(0, 5, 0, 0);
        do_reset("t6_rst0");
        step_ticks(4);
        check_state("t6_clr", 1, 1, 4'b0000);
        do_reset("t6_rst");
        begin
            int k = 0;
            for (int i = 1; i <= 8 && k == 0; i++) begin
                @(negedge clk);
                if (tick) k = i;
            end
            check("t6_tick_lat", k, 4);
            @(posedge clk); #1;
        end
        check_state("t6_k1", 0, 1, 4'b1010);

        // 7: manual pin to B from A, clearance still honoured
        set_q(0, 0, 0, 0);
        man_en = 1'b1; man_sel = 1'b1;
        do_reset("t7_rst");
        step_tick();
        check_state("t7_k1", 1, 0, 4'b0000);
        step_tick();
        check_state("t7_k2", 1, 1, 4'b0000);
        step_tick();
        check_state("t7_k3", 2, 0, 4'b0101);
        q1 = 8'd20;
        step_ticks(10);
        check_state("t7_hold", 2, 10, 4'b0101);
        man_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
